// File: rtl/cache_bus_pkg.sv
// Shared types for the cache-to-bridge path: arbiter state encoding, access
// size codes and the request record carried by the i_cache/d_cache miss ports.
package cache_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam int BUS_AW = 32;
   localparam int BUS_DW = 32;

   typedef struct packed {
      logic [BUS_AW-1:0] addr;
      logic              write;
      logic [1:0]        size;
      logic [3:0]        sel;
      logic [BUS_DW-1:0] wdata;
   } cache_req_t;

   // An instruction fill is always a full-word read with every lane enabled.
   function automatic cache_req_t i_fill_req(input logic [BUS_AW-1:0] addr);
      cache_req_t r;
      r.addr  = addr;
      r.write = 1'b0;
      r.size  = SZ_WORD;
      r.sel   = 4'hF;
      r.wdata = '0;
      return r;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: a lone request wins outright, a tie goes
// to the side that did not win last time.
module rr_arb2 #(
   parameter bit I_FIRST = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic req_i,
   input  logic req_d,
   input  logic advance,
   output logic grant_i,
   output logic grant_d
);

   logic last_i_q;

   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (req_i && req_d) begin
         grant_i = !last_i_q;
         grant_d = last_i_q;
      end else begin
         grant_i = req_i;
         grant_d = req_d;
      end
   end

   // Reset to the opposite of I_FIRST so the first tie lands on I_FIRST's side.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_i_q <= !I_FIRST;
      end else if (advance && (grant_i || grant_d)) begin
         last_i_q <= grant_i;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Registered arbiter between the i_cache/d_cache miss ports and the
// single-outstanding bridge; request fields are latched at grant and held.
module cache_mem_arbiter
   import cache_bus_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter bit I_FIRST = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_strobe,
   input  logic [AW-1:0] i_addr,
   output logic          i_ready,
   output logic [DW-1:0] i_rdata,
   input  logic          d_strobe,
   input  logic [AW-1:0] d_addr,
   input  logic          d_rw,
   input  logic [1:0]    d_size,
   input  logic [3:0]    d_wen,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ready,
   output logic [DW-1:0] d_rdata,
   output logic [AW-1:0] mem_a,
   output logic          mem_access,
   output logic          mem_write,
   output logic [1:0]    mem_size,
   output logic [3:0]    mem_sel,
   output logic [DW-1:0] mem_st_data,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_data,
   output logic          owner_i
);

   arb_state_t state_q;
   arb_state_t state_d;
   logic       grant_i;
   logic       grant_d;
   logic       arb_en;
   logic       owner_live;

   // Arbitration is only meaningful while no transaction is in flight.
   assign arb_en = (state_q == IDLE);

   rr_arb2 #(
      .I_FIRST (I_FIRST)
   ) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req_i   (i_strobe),
      .req_d   (d_strobe),
      .advance (arb_en),
      .grant_i (grant_i),
      .grant_d (grant_d)
   );

   // A cache that dropped its strobe mid-transaction has abandoned it.
   assign owner_live = (state_q == BUSY_I) ? i_strobe : d_strobe;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (grant_i) begin
               state_d = BUSY_I;
            end else if (grant_d) begin
               state_d = BUSY_D;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ready) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_a       <= '0;
         mem_access  <= 1'b0;
         mem_write   <= 1'b0;
         mem_size    <= 2'd0;
         mem_sel     <= 4'd0;
         mem_st_data <= '0;
         i_ready     <= 1'b0;
         d_ready     <= 1'b0;
         i_rdata     <= '0;
         d_rdata     <= '0;
         owner_i     <= 1'b0;
      end else begin
         i_ready <= 1'b0;
         d_ready <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (grant_i) begin
                  mem_a       <= i_addr;
                  mem_access  <= 1'b1;
                  mem_write   <= 1'b0;
                  mem_size    <= SZ_WORD;
                  mem_sel     <= 4'hF;
                  mem_st_data <= '0;
                  owner_i     <= 1'b1;
               end else if (grant_d) begin
                  mem_a       <= d_addr;
                  mem_access  <= 1'b1;
                  mem_write   <= d_rw;
                  mem_size    <= d_size;
                  mem_sel     <= d_wen;
                  mem_st_data <= d_wdata;
                  owner_i     <= 1'b0;
               end
            end
            BUSY_I, BUSY_D: begin
               if (mem_ready) begin
                  mem_access <= 1'b0;
                  if (owner_live) begin
                     if (state_q == BUSY_I) begin
                        i_rdata <= mem_data;
                        i_ready <= 1'b1;
                     end else begin
                        // A store has no load data to hand back.
                        if (!mem_write) begin
                           d_rdata <= mem_data;
                        end
                        d_ready <= 1'b1;
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a transaction-level reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_cache_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_strobe;
   logic [AW-1:0] i_addr;
   logic          i_ready;
   logic [DW-1:0] i_rdata;
   logic          d_strobe;
   logic [AW-1:0] d_addr;
   logic          d_rw;
   logic [1:0]    d_size;
   logic [3:0]    d_wen;
   logic [DW-1:0] d_wdata;
   logic          d_ready;
   logic [DW-1:0] d_rdata;
   logic [AW-1:0] mem_a;
   logic          mem_access;
   logic          mem_write;
   logic [1:0]    mem_size;
   logic [3:0]    mem_sel;
   logic [DW-1:0] mem_st_data;
   logic          mem_ready;
   logic [DW-1:0] mem_data;
   logic          owner_i;

   int errors = 0;
   int checks = 0;

   cache_mem_arbiter #(.AW(AW), .DW(DW), .I_FIRST(1'b1)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_strobe    (i_strobe),
      .i_addr      (i_addr),
      .i_ready     (i_ready),
      .i_rdata     (i_rdata),
      .d_strobe    (d_strobe),
      .d_addr      (d_addr),
      .d_rw        (d_rw),
      .d_size      (d_size),
      .d_wen       (d_wen),
      .d_wdata     (d_wdata),
      .d_ready     (d_ready),
      .d_rdata     (d_rdata),
      .mem_a       (mem_a),
      .mem_access  (mem_access),
      .mem_write   (mem_write),
      .mem_size    (mem_size),
      .mem_sel     (mem_sel),
      .mem_st_data (mem_st_data),
      .mem_ready   (mem_ready),
      .mem_data    (mem_data),
      .owner_i     (owner_i)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_owner: 0 none, 1 I, 2 D.  m_gap: the one response cycle with no arbitration.
   int            m_owner = 0;
   int            m_gap   = 0;
   bit            m_last_i;
   bit            m_valid = 1'b0;
   bit            m_take_i;
   logic          m_access, m_write, m_ir, m_dr, m_own_i;
   logic [AW-1:0] m_a;
   logic [1:0]    m_size;
   logic [3:0]    m_sel;
   logic [DW-1:0] m_wd, m_ird, m_drd;
   logic          grant_q[$];

   always @(posedge clk) begin
      if (rst) begin
         m_owner = 0; m_gap = 0; m_last_i = 1'b0;
         m_access = 0; m_write = 0; m_size = 0; m_sel = 0; m_a = 0; m_wd = 0;
         m_ir = 0; m_dr = 0; m_ird = 0; m_drd = 0; m_own_i = 0;
      end else begin
         m_ir = 0;
         m_dr = 0;
         if (m_owner != 0) begin
            if (mem_ready) begin
               if (m_owner == 1 && i_strobe) begin
                  m_ird = mem_data;
                  m_ir  = 1;
               end
               if (m_owner == 2 && d_strobe) begin
                  if (!m_write) m_drd = mem_data;
                  m_dr = 1;
               end
               m_owner  = 0;
               m_access = 0;
               m_gap    = 1;
            end
         end else if (m_gap != 0) begin
            m_gap = 0;
         end else if (i_strobe || d_strobe) begin
            m_take_i = i_strobe && (!d_strobe || !m_last_i);
            m_last_i = m_take_i;
            m_own_i  = m_take_i;
            m_access = 1;
            grant_q.push_back(m_take_i);
            if (m_take_i) begin
               m_owner = 1; m_a = i_addr; m_write = 0; m_size = 2'd2; m_sel = 4'hF; m_wd = 0;
            end else begin
               m_owner = 2; m_a = d_addr; m_write = d_rw; m_size = d_size; m_sel = d_wen; m_wd = d_wdata;
            end
         end
      end
      m_valid = 1'b1;
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         chk("mem_access", mem_access, m_access);
         if (m_access) begin
            chk("mem_a", mem_a, m_a);
            chk("mem_write", mem_write, m_write);
            chk("mem_size", mem_size, m_size);
            chk("mem_sel", mem_sel, m_sel);
            chk("mem_st_data", mem_st_data, m_wd);
         end
         chk("i_ready", i_ready, m_ir);
         chk("d_ready", d_ready, m_dr);
         chk("i_rdata", i_rdata, m_ird);
         chk("d_rdata", d_rdata, m_drd);
         chk("owner_i", owner_i, m_own_i);
      end
   end

   // ---------------- bridge driver ----------------
   // Waits for a request, holds it lat cycles, answers with data; exp_a pins mem_a.
   task automatic serve(input int lat, input logic [DW-1:0] data,
                        input logic [AW-1:0] exp_a, input bit churn);
      int n;
      n = 0;
      while (!mem_access && n < 50) begin
         step();
         n++;
      end
      if (!mem_access) begin
         chk("serve_timeout", 32'd0, 32'd1);
         return;
      end
      for (int k = 0; k < lat; k++) begin
         chk("serve_addr", mem_a, exp_a);
         if (churn) d_addr = 32'h9000_0000 + 32'(k * 16);
         if (k == lat - 1) begin
            mem_ready = 1'b1;
            mem_data  = data;
         end
         step();
      end
      mem_ready = 1'b0;
      mem_data  = 32'hDEAD_BEEF;
   endtask

   task automatic turnaround(input string name);
      int k;
      k = 0;
      while (!mem_access && k < 10) begin
         step();
         k++;
      end
      chk(name, 32'(k), 32'd2);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; i_strobe = 0; i_addr = 0; d_strobe = 0; d_addr = 0; d_rw = 0;
      d_size = 0; d_wen = 0; d_wdata = 0; mem_ready = 0; mem_data = 0;
      step();
      step();
      rst = 1'b0;
      chk("rst_mem_access", mem_access, 32'd0);
      chk("rst_mem_a", mem_a, 32'd0);
      chk("rst_owner_i", owner_i, 32'd0);
      chk("rst_state", dut.state_q, 32'd0);

      // I only
      i_strobe = 1; i_addr = 32'hBFC0_0000;
      serve(3, 32'h3C1A_0001, 32'hBFC0_0000, 1'b0);
      i_strobe = 0;
      chk("i_only_ready", i_ready, 32'd1);
      chk("i_only_rdata", i_rdata, 32'h3C1A_0001);
      chk("i_only_d_ready", d_ready, 32'd0);
      step();
      chk("i_only_pulse_end", i_ready, 32'd0);
      repeat (2) step();

      // D write
      d_strobe = 1; d_rw = 1; d_addr = 32'h8000_1004; d_size = 2'd0;
      d_wen = 4'b0010; d_wdata = 32'h0000_AB00;
      step();
      chk("dw_write", mem_write, 32'd1);
      chk("dw_sel", mem_sel, 32'h2);
      chk("dw_size", mem_size, 32'd0);
      serve(2, 32'h5555_5555, 32'h8000_1004, 1'b0);
      d_strobe = 0;
      chk("dw_ready", d_ready, 32'd1);
      chk("dw_rdata_kept", d_rdata, 32'd0);
      repeat (3) step();

      // Contention: both held high
      i_strobe = 1; i_addr = 32'h0000_1000;
      d_strobe = 1; d_addr = 32'h0000_2000; d_rw = 0; d_size = 2'd2; d_wen = 4'hF; d_wdata = 0;
      step();
      chk("cont_first_owner", owner_i, 32'd1);
      serve(2, 32'h1111_0001, 32'h0000_1000, 1'b0);
      turnaround("cont_turn1");
      chk("cont_owner2", owner_i, 32'd0);
      serve(2, 32'h2222_0002, 32'h0000_2000, 1'b0);
      turnaround("cont_turn2");
      chk("cont_owner3", owner_i, 32'd1);
      serve(1, 32'h1111_0003, 32'h0000_1000, 1'b0);
      turnaround("cont_turn3");
      chk("cont_owner4", owner_i, 32'd0);
      serve(3, 32'h2222_0004, 32'h0000_2000, 1'b0);
      i_strobe = 0; d_strobe = 0;
      chk("cont_d_rdata", d_rdata, 32'h2222_0004);
      chk("cont_i_rdata", i_rdata, 32'h1111_0003);
      chk("cont_grants", grant_q.size(), 32'd6);
      if (grant_q.size() == 6) begin
         chk("cont_g2", grant_q[2], 32'd1);
         chk("cont_g3", grant_q[3], 32'd0);
         chk("cont_g4", grant_q[4], 32'd1);
         chk("cont_g5", grant_q[5], 32'd0);
      end
      repeat (3) step();

      // Abort: i_strobe dropped one cycle after grant
      i_strobe = 1; i_addr = 32'h1F00_0000;
      step();
      chk("ab_access", mem_access, 32'd1);
      step();
      i_strobe = 0;
      repeat (2) begin
         chk("ab_addr", mem_a, 32'h1F00_0000);
         step();
      end
      chk("ab_addr", mem_a, 32'h1F00_0000);
      mem_ready = 1; mem_data = 32'h7777_7777;
      step();
      mem_ready = 0;
      chk("ab_no_ready", i_ready, 32'd0);
      chk("ab_rdata_kept", i_rdata, 32'h1111_0003);
      step();
      chk("ab_idle", dut.state_q, 32'd0);
      repeat (2) step();

      // Reset during BUSY_D, then a stray mem_ready
      d_strobe = 1; d_rw = 0; d_addr = 32'h8000_3000; d_size = 2'd1; d_wen = 4'b0011;
      step();
      d_strobe = 0;
      step();
      rst = 1;
      step();
      rst = 0;
      mem_ready = 1; mem_data = 32'h0BAD_0BAD;
      step();
      mem_ready = 0;
      chk("rr_access", mem_access, 32'd0);
      chk("rr_d_ready", d_ready, 32'd0);
      chk("rr_d_rdata", d_rdata, 32'd0);
      chk("rr_i_rdata", i_rdata, 32'd0);
      chk("rr_state", dut.state_q, 32'd0);
      step();

      // D read after reset, with address churn during the transaction
      d_strobe = 1; d_rw = 0; d_addr = 32'h8000_2000; d_size = 2'd2; d_wen = 4'hF;
      serve(4, 32'hCAFE_F00D, 32'h8000_2000, 1'b1);
      d_strobe = 0;
      chk("dr_ready", d_ready, 32'd1);
      chk("dr_rdata", d_rdata, 32'hCAFE_F00D);
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
